// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// It performs one shift/correct iteration per clock and uses a start/busy/done handshake.
module bcd_to_bin_seq #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [0:4*DIGITS-1]   bcdIn,
   output logic                  busy,
   output logic                  done,
   output logic [0:BIN_W-1]      binOut,
   output logic                  isValid
);

   localparam int W     = 4 * DIGITS;
   localparam int CNT_W = $clog2(W + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [W-1:0]     bcd;
   logic [W-1:0]     bin;
   logic [CNT_W-1:0] cnt;
   logic             operand_ok;
   logic [W-1:0]     bcd_flat;
   logic [W-1:0]     bcd_next;
   logic [W-1:0]     bin_next;

   // Ascending-range port remapped to a descending vector; bcdIn[0] becomes bcd_flat[W-1].
   assign bcd_flat = bcdIn;

   function automatic logic digits_ok(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int d = 0; d < DIGITS; d++)
         if (v[4*d +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [W-1:0] dabble(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int d = 0; d < DIGITS; d++)
         if (r[4*d +: 4] >= 4'd8) r[4*d +: 4] = r[4*d +: 4] - 4'd3;
      return r;
   endfunction

   assign bin_next = {bcd[0], bin[W-1:1]};
   assign bcd_next = dabble({1'b0, bcd[W-1:1]});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         bcd        <= '0;
         bin        <= '0;
         cnt        <= '0;
         operand_ok <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         binOut     <= '0;
         isValid    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SHIFT;
                  bcd        <= bcd_flat;
                  bin        <= '0;
                  cnt        <= '0;
                  operand_ok <= digits_ok(bcd_flat);
                  busy       <= 1'b1;
               end
            end
            SHIFT: begin
               bcd <= bcd_next;
               bin <= bin_next;
               cnt <= cnt + CNT_W'(1);
               // Invalid operands still run all iterations so latency stays fixed.
               if (cnt == LAST) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  binOut  <= operand_ok ? bin_next[BIN_W-1:0] : '0;
                  isValid <= operand_ok;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed and randomized bench for bcd_to_bin_seq.
// It checks the result value, fixed latency, the done pulse width and the busy rules.
module tb_bcd_to_bin_seq;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [0:15] bcdIn;
   logic        busy;
   logic        done;
   logic [0:13] binOut;
   logic        isValid;

   int checks;
   int failures;

   bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .bcdIn   (bcdIn),
      .busy    (busy),
      .done    (done),
      .binOut  (binOut),
      .isValid (isValid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called #1 after an edge; start is sampled at E0 and done is expected at E16.
   task automatic conv(input logic [15:0] v, input int exp_bin, input logic exp_valid,
                       input bit hold, input int pulse_at);
      int bad;
      start = 1'b1;
      bcdIn = v;
      @(posedge clk); #1;
      check("busy_e0", busy, 1);
      check("done_e0", done, 0);
      bad = 0;
      for (int i = 1; i <= 15; i++) begin
         start = hold || (i == pulse_at);
         bcdIn = (hold || pulse_at > 0) ? ~v : v;
         @(posedge clk); #1;
         if (done)  bad++;
         if (!busy) bad++;
      end
      check("early_done_or_idle", bad, 0);
      start = hold;
      @(posedge clk); #1;
      check("done_e16", done, 1);
      check("busy_e16", busy, 1);
      check("bin_e16", binOut, exp_bin);
      check("valid_e16", isValid, exp_valid);
      @(posedge clk); #1;
      check("done_e17", done, 0);
      check("busy_e17", busy, 0);
      check("bin_hold_e17", binOut, exp_bin);
   endtask

   initial begin
      logic [15:0] v;
      int d3, d2, d1, d0, ndone;
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      start    = 1'b0;
      bcdIn    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bin", binOut, 0);
      check("rst_valid", isValid, 0);
      reset_n = 1'b1;

      conv(16'h1234, 1234, 1'b1, 1'b0, 0);
      conv(16'h9999, 9999, 1'b1, 1'b0, 0);
      conv(16'h0000, 0,    1'b1, 1'b0, 0);
      conv(16'h0001, 1,    1'b1, 1'b0, 0);
      conv(16'h12A4, 0,    1'b0, 1'b0, 0);
      conv(16'h0042, 42,   1'b1, 1'b0, 0);

      // Start held high with bcdIn changing during SHIFT, followed by an immediate re-start.
      conv(16'h0500, 500, 1'b1, 1'b1, 0);
      conv(16'h0500, 500, 1'b1, 1'b0, 0);
      // Second start pulse mid-conversion must be ignored.
      conv(16'h0500, 500, 1'b1, 1'b0, 5);
      ndone = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("no_second_done", ndone, 0);

      // Reset asserted after iteration 7 of 16'h8765.
      start = 1'b1;
      bcdIn = 16'h8765;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_bin", binOut, 0);
      check("midrst_valid", isValid, 0);
      ndone = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("midrst_no_done", ndone, 0);
      reset_n = 1'b1;
      conv(16'h0010, 10, 1'b1, 1'b0, 0);

      for (int n = 0; n < 1000; n++) begin
         d3 = $urandom_range(0, 9);
         d2 = $urandom_range(0, 9);
         d1 = $urandom_range(0, 9);
         d0 = $urandom_range(0, 9);
         v  = {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
         conv(v, d3*1000 + d2*100 + d1*10 + d0, 1'b1, 1'b0, 0);
      end

      start = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
